div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Sequential signed restoring divider (quotient truncates toward zero, remainder takes dividend sign).
// Latency: done is high in the cycle after edge E+WIDTH+1 for an accepting edge E (E+1 for b=0 when DIV_ZERO_FAST_EN is defined).
// Backpressure: none; start is accepted only in IDLE/DONE and silently ignored while busy.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, a, b         : request strobe, signed dividend, signed divisor
//   busy                : high in CALC and FIX
//   done                : one-cycle pulse, q/r/div_by_zero valid
//   q, r, div_by_zero   : signed quotient, signed remainder, divisor-was-zero flag
// Build option: define DIV_ZERO_FAST_EN to skip the iteration loop when b == 0.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder magnitude
  logic [WIDTH-1:0] quo_q, quo_d;      // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dvsr_q, dvsr_d;    // |b|
  logic             sign_a_q, sign_a_d;
  logic             neg_q_q, neg_q_d;  // sign(a) ^ sign(b)
  logic             bzero_q, bzero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_shift;         // (WIDTH+1)-bit partial remainder for this step
  logic [WIDTH:0]   trial;

  always_comb begin
    // Magnitudes; the most negative value maps to itself, which is its correct unsigned magnitude.
    abs_a     = a[WIDTH-1] ? -a : a;
    abs_b     = b[WIDTH-1] ? -b : b;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvsr_q};

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    sign_a_d = sign_a_q;
    neg_q_d  = neg_q_q;
    bzero_d  = bzero_q;
    q_d      = q_q;
    r_d      = r_q;
    dbz_d    = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          sign_a_d = a[WIDTH-1];
          neg_q_d  = a[WIDTH-1] ^ b[WIDTH-1];
          bzero_d  = (b == '0);
          dvsr_d   = abs_b;
          quo_d    = abs_a;
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
`ifdef DIV_ZERO_FAST_EN
          // Skip the loop: FIX only needs |a| in the remainder register to return r = a.
          if (b == '0) begin
            rem_d   = abs_a;
            quo_d   = '1;
            state_d = FIX;
          end
`endif
        end
      end

      CALC: begin
        // Restoring step: keep the subtraction only if it did not go negative.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // With b == 0 the loop leaves |a| in the remainder, so r = a falls out of the
        // normal sign fix; only the quotient needs overriding.
        if (bzero_q) begin
          q_d = '1;
        end else begin
          q_d = neg_q_q ? -quo_q : quo_q;
        end
        r_d     = sign_a_q ? -rem_q : rem_q;
        dbz_d   = bzero_q;
        state_d = DONE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      sign_a_q <= 1'b0;
      neg_q_q  <= 1'b0;
      bzero_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      q_q      <= '0;
      r_q      <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      sign_a_q <= sign_a_d;
      neg_q_q  <= neg_q_d;
      bzero_q  <= bzero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      q_q      <= q_d;
      r_q      <= r_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule
